// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer.
//   state_t    : controller phases, in the order a run visits them
//   DEFAULT_N  : default matrix dimension
//   addr_width : address bits needed to index N*N elements (at least 1)
//   cnt_width  : bits needed for a 0..N-1 loop counter (at least 1)
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CALC,
        WRITE,
        OUT,
        DONE
    } state_t;

    localparam int DEFAULT_N = 3;

    function automatic int addr_width(input int n);
        return (n * n <= 1) ? 1 : $clog2(n * n);
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_index_gen.sv
// i/j/k loop counters and incremental address generation for the MAC phase.
// Ports:
//   clk, srst        clock and synchronous active-high reset
//   k_step           one CALC cycle: advance k (wraps after N-1)
//   ij_step          one WRITE cycle: advance j, and i when j wraps
//   k_first, k_last  k == 0 / k == N-1
//   ij_last          i == N-1 and j == N-1 (last C element)
//   a_addr           i*N + k
//   b_addr           k*N + j
//   c_addr           i*N + j
// No multipliers: every address is kept as a running sum.
module matmul_index_gen
    import matmul_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int AW = addr_width(DEFAULT_N)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          k_step,
    input  logic          ij_step,
    output logic          k_first,
    output logic          k_last,
    output logic          ij_last,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic [AW-1:0] c_addr
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [AW-1:0] STEP = AW'(N);

    logic [CW-1:0] k_reg, j_reg, i_reg;
    logic [AW-1:0] row_base_reg;   // i*N
    logic [AW-1:0] a_addr_reg, b_addr_reg, c_addr_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            k_reg        <= '0;
            j_reg        <= '0;
            i_reg        <= '0;
            row_base_reg <= '0;
            a_addr_reg   <= '0;
            b_addr_reg   <= '0;
            c_addr_reg   <= '0;
        end else begin
            if (k_step) begin
                if (k_reg == LAST) begin
                    // Rewind to the start of the current dot product.
                    k_reg      <= '0;
                    a_addr_reg <= row_base_reg;
                    b_addr_reg <= AW'(j_reg);
                end else begin
                    k_reg      <= k_reg + CW'(1);
                    a_addr_reg <= a_addr_reg + AW'(1);
                    b_addr_reg <= b_addr_reg + STEP;
                end
            end
            if (ij_step) begin
                // C is written in row-major order, so its address just counts.
                c_addr_reg <= ij_last ? '0 : c_addr_reg + AW'(1);
                if (j_reg == LAST) begin
                    j_reg      <= '0;
                    b_addr_reg <= '0;
                    if (i_reg == LAST) begin
                        i_reg        <= '0;
                        row_base_reg <= '0;
                        a_addr_reg   <= '0;
                    end else begin
                        i_reg        <= i_reg + CW'(1);
                        row_base_reg <= row_base_reg + STEP;
                        a_addr_reg   <= row_base_reg + STEP;
                    end
                end else begin
                    j_reg      <= j_reg + CW'(1);
                    b_addr_reg <= AW'(j_reg) + AW'(1);
                    a_addr_reg <= row_base_reg;
                end
            end
        end
    end

    assign k_first = (k_reg == '0);
    assign k_last  = (k_reg == LAST);
    assign ij_last = (i_reg == LAST) && (j_reg == LAST);
    assign a_addr  = a_addr_reg;
    assign b_addr  = b_addr_reg;
    assign c_addr  = c_addr_reg;

endmodule

// File: rtl/matmul_controller.sv
// Sequencing FSM for an N x N matrix multiplier built around one MAC unit.
// Loads A then B from the shared data bus, runs i/j/k over the MAC, writes
// each C element, then streams C out and pulses done.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   st                start request, only looked at in IDLE
//   busy, done        status; done pulses for one cycle at the end of a run
//   a_we, b_we        A/B memory write strobes, element index on wr_addr
//   a_addr, b_addr    A/B read addresses during CALC
//   mac_en, mac_clr   MAC accumulate / restart-with-product
//   c_we, c_addr      C memory write strobe and address
//   out_valid         C[out_addr] is on the data output this cycle
module matmul_controller
    import matmul_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int AW = addr_width(DEFAULT_N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st,
    output logic          busy,
    output logic          done,
    output logic          a_we,
    output logic          b_we,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          c_we,
    output logic [AW-1:0] c_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr
);

    localparam logic [AW-1:0] CNT_LAST = AW'(N * N - 1);

    state_t        state_reg, state_next;
    logic [AW-1:0] cnt_reg;   // element index, shared by LOAD_A, LOAD_B and OUT
    logic          cnt_last;
    logic          k_step, ij_step;
    logic          k_first, k_last, ij_last;

    assign cnt_last = (cnt_reg == CNT_LAST);

    matmul_index_gen #(
        .N  (N),
        .AW (AW)
    ) u_index_gen (
        .clk     (clk),
        .srst    (rst),
        .k_step  (k_step),
        .ij_step (ij_step),
        .k_first (k_first),
        .k_last  (k_last),
        .ij_last (ij_last),
        .a_addr  (a_addr),
        .b_addr  (b_addr),
        .c_addr  (c_addr)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Element counter: wraps to zero at the end of each streaming phase so
    // the next phase starts at element 0 without extra control.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (state_reg == LOAD_A || state_reg == LOAD_B || state_reg == OUT) begin
            cnt_reg <= cnt_last ? '0 : cnt_reg + AW'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (st)       state_next = LOAD_A;
            LOAD_A:  if (cnt_last) state_next = LOAD_B;
            LOAD_B:  if (cnt_last) state_next = CALC;
            CALC:    if (k_last)   state_next = WRITE;
            WRITE:   state_next = ij_last ? OUT : CALC;
            OUT:     if (cnt_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy      = (state_reg != IDLE);
        done      = 1'b0;
        a_we      = 1'b0;
        b_we      = 1'b0;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        c_we      = 1'b0;
        out_valid = 1'b0;
        k_step    = 1'b0;
        ij_step   = 1'b0;
        case (state_reg)
            LOAD_A:  a_we = 1'b1;
            LOAD_B:  b_we = 1'b1;
            CALC: begin
                mac_en  = 1'b1;
                mac_clr = k_first;
                k_step  = 1'b1;
            end
            WRITE: begin
                c_we    = 1'b1;
                ij_step = 1'b1;
            end
            OUT:     out_valid = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign wr_addr  = cnt_reg;
    assign out_addr = cnt_reg;

endmodule

// File: tb/tb_matmul_controller.sv
// Scoreboard bench for matmul_controller: an N=3 instance driving a small
// behavioural memory/MAC datapath, plus an N=1 instance for the degenerate
// size. Expected per-cycle controls and expected output bytes are queued
// when a run is issued; the monitor pops and compares every cycle.
module tb_matmul_controller;

    localparam int N      = 3;
    localparam int AW     = 4;
    localparam int NN     = N * N;
    localparam int DONE_C = 3 * NN + NN * (N + 1) + 1;

    typedef struct {
        logic [47:0] exp;
        logic [47:0] mask;
        int          cyc;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, st, st1;
    logic [7:0] data_in;

    // N=3 instance
    logic          busy, done, a_we, b_we, mac_en, mac_clr, c_we, out_valid;
    logic [AW-1:0] wr_addr, a_addr, b_addr, c_addr, out_addr;

    matmul_controller #(.N(N), .AW(AW)) dut (
        .clk(clk), .rst(rst), .st(st), .busy(busy), .done(done),
        .a_we(a_we), .b_we(b_we), .wr_addr(wr_addr),
        .a_addr(a_addr), .b_addr(b_addr),
        .mac_en(mac_en), .mac_clr(mac_clr),
        .c_we(c_we), .c_addr(c_addr),
        .out_valid(out_valid), .out_addr(out_addr)
    );

    // N=1 instance
    logic       busy1, done1, a_we1, b_we1, mac_en1, mac_clr1, c_we1, out_valid1;
    logic [0:0] wr_addr1, a_addr1, b_addr1, c_addr1, out_addr1;

    matmul_controller #(.N(1), .AW(1)) dut1 (
        .clk(clk), .rst(rst), .st(st1), .busy(busy1), .done(done1),
        .a_we(a_we1), .b_we(b_we1), .wr_addr(wr_addr1),
        .a_addr(a_addr1), .b_addr(b_addr1),
        .mac_en(mac_en1), .mac_clr(mac_clr1),
        .c_we(c_we1), .c_addr(c_addr1),
        .out_valid(out_valid1), .out_addr(out_addr1)
    );

    // Behavioural datapath for the N=3 instance
    logic [7:0]  a_mem [16];
    logic [7:0]  b_mem [16];
    logic [31:0] c_mem [16];
    logic [31:0] acc;
    logic [7:0]  dataout;

    always @(posedge clk) begin
        if (a_we) a_mem[wr_addr] <= data_in;
        if (b_we) b_mem[wr_addr] <= data_in;
        if (mac_en) acc <= (mac_clr ? 32'd0 : acc) + 32'(a_mem[a_addr]) * 32'(b_mem[b_addr]);
        if (c_we) c_mem[c_addr] <= acc;
    end
    assign dataout = c_mem[out_addr][7:0];

    // Scoreboard state
    frame_t q0[$];
    frame_t q1[$];
    int     data_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     mon_en = 1'b0;
    logic [7:0] mat_a [NN];
    logic [7:0] mat_b [NN];

    // Expected controls at cycle c of a run (cycle 0 = the IDLE cycle in which
    // st is sampled), derived from the phase lengths. Only addresses whose
    // strobe is active are compared, except in strict (post-reset) frames.
    // Control bits: busy,done,a_we,b_we,mac_en,mac_clr,c_we,out_valid.
    function automatic frame_t make_frame(input int n, input int c, input bit strict);
        frame_t     f;
        int         nn, calc_end, out_end, r, e, k;
        int         wr, aa, ba, ca, oa;
        logic [7:0] ctl;
        logic [4:0] am;
        nn = n * n;
        calc_end = 2 * nn + nn * (n + 1);
        out_end  = calc_end + nn;
        ctl = '0; am = '0;
        wr = 0; aa = 0; ba = 0; ca = 0; oa = 0;
        if (c == 0) begin
            if (strict) am = 5'b11111;
        end else if (c <= nn) begin
            ctl = 8'hA0; wr = c - 1; am = 5'b10000;
        end else if (c <= 2 * nn) begin
            ctl = 8'h90; wr = c - nn - 1; am = 5'b10000;
        end else if (c <= calc_end) begin
            r = c - 2 * nn - 1;
            e = r / (n + 1);
            k = r % (n + 1);
            if (k < n) begin
                ctl = (k == 0) ? 8'h8C : 8'h88;
                aa  = (e / n) * n + k;
                ba  = k * n + (e % n);
                am  = 5'b01100;
            end else begin
                ctl = 8'h82; ca = e; am = 5'b00010;
            end
        end else if (c <= out_end) begin
            ctl = 8'h81; oa = c - calc_end - 1; am = 5'b00001;
        end else if (c == out_end + 1) begin
            ctl = 8'hC0;
        end
        f.exp  = {ctl, 8'(wr), 8'(aa), 8'(ba), 8'(ca), 8'(oa)};
        f.mask = {8'hFF, {8{am[4]}}, {8{am[3]}}, {8{am[2]}}, {8{am[1]}}, {8{am[0]}}};
        f.cyc  = c;
        return f;
    endfunction

    // Monitor: one trace comparison per instance per cycle, plus a data
    // comparison whenever the N=3 instance presents an output element.
    frame_t      f0, f1;
    logic [47:0] act0, act1;
    int          exp_d;

    always @(negedge clk) begin
        if (mon_en) begin
            f0 = (q0.size() > 0) ? q0.pop_front() : make_frame(N, 0, 1'b0);
            if (q0.size() == 0 && f0.cyc == 0 && f0.mask[39:0] == '0) f0.cyc = -1;
            act0 = {busy, done, a_we, b_we, mac_en, mac_clr, c_we, out_valid,
                    8'(wr_addr), 8'(a_addr), 8'(b_addr), 8'(c_addr), 8'(out_addr)};
            checks++;
            if ((act0 & f0.mask) !== (f0.exp & f0.mask)) begin
                errors++;
                $display("FAIL trace_n3 cycle %0d: got %h required %h (mask %h)",
                         f0.cyc, act0, f0.exp, f0.mask);
            end

            f1 = (q1.size() > 0) ? q1.pop_front() : make_frame(1, 0, 1'b0);
            act1 = {busy1, done1, a_we1, b_we1, mac_en1, mac_clr1, c_we1, out_valid1,
                    8'(wr_addr1), 8'(a_addr1), 8'(b_addr1), 8'(c_addr1), 8'(out_addr1)};
            checks++;
            if ((act1 & f1.mask) !== (f1.exp & f1.mask)) begin
                errors++;
                $display("FAIL trace_n1 cycle %0d: got %h required %h (mask %h)",
                         f1.cyc, act1, f1.exp, f1.mask);
            end

            if (out_valid === 1'b1) begin
                checks++;
                if (data_q.size() == 0) begin
                    errors++;
                    $display("FAIL dataout: unexpected element %0d at out_addr %0d, none required",
                             dataout, out_addr);
                end else begin
                    exp_d = data_q.pop_front();
                    if (int'(dataout) !== exp_d) begin
                        errors++;
                        $display("FAIL dataout out_addr %0d: got %0d required %0d",
                                 out_addr, dataout, exp_d);
                    end else begin
                        $display("out[%0d] = %0d", out_addr, dataout);
                    end
                end
            end
        end
    end

    // Issue one N=3 run starting in the current (IDLE) cycle.
    //   abort_c  : >0 asserts rst during that run cycle
    //   st_mode  : st while busy: 0 low, 1 high in cycles 30-35, 2 random
    //   hold_next: leave st high at the end so the next run follows directly
    task automatic start_run(input int abort_c, input int st_mode,
                             input bit hold_next, input bit strict0);
        int     last_c, s;
        frame_t z;
        last_c = (abort_c > 0) ? abort_c : DONE_C;
        st = 1'b1;
        data_in = 8'($urandom);
        for (int c = 0; c <= last_c; c++) begin
            q0.push_back(make_frame(N, c, (c == 0) && strict0));
        end
        if (abort_c > 0) begin
            z = make_frame(N, 0, 1'b1);
            z.cyc = abort_c + 1;
            q0.push_back(z);
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    s = 0;
                    for (int k = 0; k < N; k++) begin
                        s += int'(mat_a[i * N + k]) * int'(mat_b[k * N + j]);
                    end
                    data_q.push_back(s & 255);
                end
            end
        end
        $display("run issued: abort_cycle=%0d st_mode=%0d hold_next=%0d", abort_c, st_mode, hold_next);
        for (int c = 1; c <= last_c; c++) begin
            @(posedge clk); #1;
            if (c <= NN)          data_in = mat_a[c - 1];
            else if (c <= 2 * NN) data_in = mat_b[c - NN - 1];
            else                  data_in = 8'($urandom);
            case (st_mode)
                1:       st = (c >= 30 && c <= 35);
                2:       st = 1'($urandom_range(0, 1));
                default: st = 1'b0;
            endcase
            if (c == DONE_C) st = hold_next;
            if (c == abort_c) begin
                rst = 1'b1;
                st  = 1'b0;
            end
        end
        if (abort_c > 0) begin
            @(posedge clk); #1;
            rst = 1'b0;
        end
    endtask

    task automatic random_mats();
        for (int e = 0; e < NN; e++) begin
            mat_a[e] = 8'($urandom);
            mat_b[e] = 8'($urandom);
        end
    endtask

    initial begin
        rst = 1'b1;
        st = 1'b1;
        st1 = 1'b0;
        data_in = '0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        q0.push_back(make_frame(N, 0, 1'b1));
        q1.push_back(make_frame(1, 0, 1'b1));
        @(posedge clk); #1;
        rst = 1'b0;

        // Fixed A = B = 1..9, st held through reset, st pulses while busy
        for (int e = 0; e < NN; e++) begin
            mat_a[e] = 8'(e + 1);
            mat_b[e] = 8'(e + 1);
        end
        start_run(0, 1, 1'b0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end

        // Reset in the middle of CALC, then a fresh run
        random_mats();
        start_run(25, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        random_mats();
        start_run(0, 0, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end

        // Random runs, back to back with st still high on return to IDLE
        random_mats();
        start_run(0, 2, 1'b1, 1'b0);
        @(posedge clk); #1;
        random_mats();
        start_run(0, 2, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end

        // N=1 instance: every phase lasts one cycle
        st1 = 1'b1;
        for (int c = 0; c <= 7; c++) q1.push_back(make_frame(1, c, 1'b0));
        $display("run issued: N=1 instance");
        @(posedge clk); #1;
        st1 = 1'b0;
        repeat (9) begin @(posedge clk); #1; end

        checks++;
        if (q0.size() != 0 || q1.size() != 0 || data_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d/%0d queued entries, required 0/0/0",
                     q0.size(), q1.size(), data_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
